// File: rtl/photon_pkg.sv
// photon_pkg: shared state encoding and frame constants for the photon gate sequencer
package photon_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_WR_HDR, S_WR_CNT} state_t;
  localparam logic [7:0] DEF_HDR_MAGIC = 8'hA5;
  localparam int FRAME_WORDS = 2;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: loadable down-counting prescaler emitting a one-cycle tick every TICKS enabled cycles
module ms_tick_gen #(
  parameter int TICKS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(TICKS + 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == '0;
  // reload on load or on each tick so ticks repeat every TICKS enabled cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load || tick) cnt <= W'(TICKS - 1);
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/photon_gate_sequencer.sv
// photon_gate_sequencer: gates the pulse counter for gate_ms and pushes a header/count frame to the result FIFO
module photon_gate_sequencer
  import photon_pkg::*;
#(
  parameter int TICKS_PER_MS = 50000,
  parameter int SETTLE_CYC = 2,
  parameter logic [7:0] HDR_MAGIC = DEF_HDR_MAGIC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        single_shot,
  input  logic [15:0] gate_ms,
  output logic        cnt_clr,
  output logic        cnt_en,
  input  logic [31:0] cnt_value,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [31:0] fifo_din,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  seq_num
);
  state_t state, nxt;
  logic [15:0] gms_q, ms_cnt;
  logic [3:0] set_cnt;
  logic [31:0] result, last_q, word;
  logic ss_q, stop_pending, tick, accept, frame_end;
  ms_tick_gen #(.TICKS(TICKS_PER_MS)) u_tick (
    .clk(clk), .rst_n(rst_n), .load(state == S_CLEAR), .en(state == S_GATE), .tick(tick)
  );
  assign accept = state == S_IDLE && start && !stop;
  assign frame_end = (state == S_WR_HDR && fifo_full) || (state == S_WR_CNT && !fifo_full);
  assign cnt_clr = state == S_CLEAR;
  assign cnt_en = state == S_GATE;
  assign busy = state != S_IDLE;
  assign fifo_wr = (state == S_WR_HDR || state == S_WR_CNT) && !fifo_full;
  assign word = state == S_WR_HDR ? {HDR_MAGIC, seq_num, gms_q} : result;
  assign fifo_din = fifo_wr ? word : last_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // next state: stop aborts before the gate completes, otherwise the frame always finishes
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = accept ? S_CLEAR : S_IDLE;
      S_CLEAR:  nxt = stop ? S_IDLE : S_GATE;
      S_GATE:   nxt = stop ? S_IDLE : (tick && ms_cnt == 16'd1) ? S_SETTLE : S_GATE;
      S_SETTLE: nxt = set_cnt == '0 ? S_WR_HDR : S_SETTLE;
      S_WR_HDR: nxt = !fifo_full ? S_WR_CNT : (ss_q || stop_pending || stop) ? S_IDLE : S_CLEAR;
      S_WR_CNT: nxt = fifo_full ? S_WR_CNT : (ss_q || stop_pending || stop) ? S_IDLE : S_CLEAR;
      default:  nxt = S_IDLE;
    endcase
  end
  // acquisition settings, timers, result latch and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gms_q <= '0;
      ss_q <= 1'b0;
      ms_cnt <= '0;
      set_cnt <= '0;
      result <= '0;
      last_q <= '0;
      seq_num <= '0;
      overrun <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      if (accept) begin
        gms_q <= gate_ms == '0 ? 16'd1 : gate_ms;
        ss_q <= single_shot;
        seq_num <= '0;
        overrun <= 1'b0;
        stop_pending <= 1'b0;
      end
      if (state == S_CLEAR) ms_cnt <= gms_q;
      else if (state == S_GATE && tick) ms_cnt <= ms_cnt - 16'd1;
      if (state == S_GATE) set_cnt <= 4'(SETTLE_CYC - 1);
      else if (state == S_SETTLE) set_cnt <= set_cnt - 4'd1;
      if (state == S_SETTLE && set_cnt == '0) result <= cnt_value;
      if (stop && (state == S_SETTLE || state == S_WR_HDR || state == S_WR_CNT)) stop_pending <= 1'b1;
      if (state == S_WR_HDR && fifo_full) overrun <= 1'b1;
      if (fifo_wr) last_q <= word;
      if (frame_end) begin
        seq_num <= seq_num + 8'd1;
        stop_pending <= 1'b0;
      end
    end
endmodule
